// File: rtl/board_pkg.sv
// Shared definitions for the board scan path: tile content codes, grid geometry
// and the scan FSM state encoding.
package board_pkg;

   localparam logic [7:0] TILE_WALL  = 8'h80;
   localparam logic [7:0] TILE_TANK1 = 8'h40;
   localparam logic [7:0] TILE_TANK2 = 8'h20;
   localparam logic [7:0] TILE_PROJ  = 8'h10;
   localparam logic [7:0] TILE_EMPTY = 8'h00;

   localparam int unsigned GRID_W    = 16;
   localparam int unsigned NUM_TILES = GRID_W * GRID_W;
   localparam logic [7:0]  LAST_TILE = 8'(NUM_TILES - 1);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_READ  = 3'd1;
   localparam logic [2:0] ST_WAIT  = 3'd2;
   localparam logic [2:0] ST_ISSUE = 3'd3;
   localparam logic [2:0] ST_DRAW  = 3'd4;
   localparam logic [2:0] ST_NEXT  = 3'd5;

   typedef enum logic [2:0] {
      StIdle  = ST_IDLE,
      StRead  = ST_READ,
      StWait  = ST_WAIT,
      StIssue = ST_ISSUE,
      StDraw  = ST_DRAW,
      StNext  = ST_NEXT
   } scan_state_e;

   // Direction lives in the low bits, so only an all-zero byte means nothing to draw.
   function automatic logic tile_is_empty(input logic [7:0] code);
      return code == TILE_EMPTY;
   endfunction

endpackage

// File: rtl/scan_timeout_counter.sv
// Saturating per-tile watchdog: cleared by load_i, counts while en_i, and flags the
// cycle in which the count reaches Limit.
module scan_timeout_counter #(
   parameter int unsigned Width = 10,
   parameter int unsigned Limit = 1023
) (
   input  logic clock,
   input  logic reset,
   input  logic load_i,
   input  logic en_i,
   output logic expired_o
);

   localparam logic [Width-1:0] LimitW = Width'(Limit);
   localparam logic [Width-1:0] LastW  = Width'(Limit - 1);

   logic [Width-1:0] count_q, count_d;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = '0;
      end else if (en_i && (count_q < LimitW)) begin
         count_d = count_q + 1'b1;
      end
   end

   // Expires on the enabled cycle whose increment lands on Limit.
   assign expired_o = en_i && (count_q >= LastW);

endmodule

// File: rtl/board_scan_controller.sv
// Walks the 16x16 board RAM in row-major order and hands each non-empty tile to the
// tile drawer, waiting for its done handshake before moving on.
module board_scan_controller
   import board_pkg::*;
#(
   parameter int unsigned RAM_LATENCY  = 1,
   parameter int unsigned SKIP_EMPTY   = 1,
   parameter int unsigned DONE_TIMEOUT = 1023
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   output logic [7:0] ram_addr,
   output logic       ram_rden,
   input  logic [7:0] ram_rdata,
   output logic [7:0] tile_addr,
   output logic [7:0] tile_code,
   output logic       tile_valid,
   input  logic       tile_done,
   output logic       vga_write_en,
   output logic       busy,
   output logic       frame_done,
   output logic       timeout_err
);

   localparam logic [1:0] LatLast = 2'(RAM_LATENCY - 1);
   localparam bit         SkipEn  = (SKIP_EMPTY != 0);

   scan_state_e state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [1:0]  lat_q, lat_d;
   logic [7:0]  tile_addr_q, tile_addr_d;
   logic [7:0]  tile_code_q, tile_code_d;
   logic        busy_q, busy_d;
   logic        frame_done_q, frame_done_d;
   logic        timeout_err_q, timeout_err_d;
   logic        tmr_load, tmr_en, tmr_expired;

   scan_timeout_counter #(
      .Width (10),
      .Limit (DONE_TIMEOUT)
   ) u_timeout (
      .clock     (clock),
      .reset     (reset),
      .load_i    (tmr_load),
      .en_i      (tmr_en),
      .expired_o (tmr_expired)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q       <= StIdle;
         cnt_q         <= '0;
         lat_q         <= '0;
         tile_addr_q   <= '0;
         tile_code_q   <= '0;
         busy_q        <= 1'b0;
         frame_done_q  <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         lat_q         <= lat_d;
         tile_addr_q   <= tile_addr_d;
         tile_code_q   <= tile_code_d;
         busy_q        <= busy_d;
         frame_done_q  <= frame_done_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      lat_d         = lat_q;
      tile_addr_d   = tile_addr_q;
      tile_code_d   = tile_code_q;
      busy_d        = busy_q;
      frame_done_d  = 1'b0;
      timeout_err_d = timeout_err_q;
      tmr_load      = 1'b0;
      tmr_en        = 1'b0;

      unique case (state_q)
         StIdle: begin
            // A start coinciding with the frame_done pulse belongs to the old frame.
            if (start && !frame_done_q) begin
               state_d       = StRead;
               busy_d        = 1'b1;
               timeout_err_d = 1'b0;
            end
         end
         StRead: begin
            lat_d   = '0;
            state_d = StWait;
         end
         StWait: begin
            lat_d = lat_q + 2'd1;
            if (lat_q == LatLast) begin
               tile_code_d = ram_rdata;
               tile_addr_d = cnt_q;
               if (SkipEn && tile_is_empty(ram_rdata)) begin
                  state_d = StNext;
               end else begin
                  state_d = StIssue;
               end
            end
         end
         StIssue: begin
            tmr_load = 1'b1;
            state_d  = StDraw;
         end
         StDraw: begin
            if (tile_done) begin
               state_d = StNext;
            end else begin
               tmr_en = 1'b1;
               if (tmr_expired) begin
                  timeout_err_d = 1'b1;
                  state_d       = StNext;
               end
            end
         end
         StNext: begin
            cnt_d = cnt_q + 8'd1;
            if (cnt_q == LAST_TILE) begin
               frame_done_d = 1'b1;
               busy_d       = 1'b0;
               state_d      = StIdle;
            end else begin
               state_d = StRead;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   assign ram_addr     = cnt_q;
   assign ram_rden     = (state_q == StRead);
   assign tile_addr    = tile_addr_q;
   assign tile_code    = tile_code_q;
   assign tile_valid   = (state_q == StIssue);
   // Combinational on tile_done so the plot stops in the very cycle done arrives.
   assign vga_write_en = (state_q == StDraw) && !tile_done;
   assign busy         = busy_q;
   assign frame_done   = frame_done_q;
   assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_board_scan_controller.sv
// Directed bench for board_scan_controller with a registered RAM model and a scripted drawer.
module tb_board_scan_controller;

   logic       clock;
   logic       reset;
   logic       start;
   logic [7:0] ram_addr;
   logic       ram_rden;
   logic [7:0] ram_rdata;
   logic [7:0] tile_addr;
   logic [7:0] tile_code;
   logic       tile_valid;
   logic       tile_done;
   logic       vga_write_en;
   logic       busy;
   logic       frame_done;
   logic       timeout_err;

   logic [7:0] mem [256];

   int n_checks = 0;
   int n_fail   = 0;

   logic       clr_mon;
   int         tv_cnt, we_cnt, fd_cnt, rden_cnt, addr_bad;
   logic [7:0] exp_addr;

   board_scan_controller #(
      .RAM_LATENCY  (1),
      .SKIP_EMPTY   (1),
      .DONE_TIMEOUT (1023)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .start        (start),
      .ram_addr     (ram_addr),
      .ram_rden     (ram_rden),
      .ram_rdata    (ram_rdata),
      .tile_addr    (tile_addr),
      .tile_code    (tile_code),
      .tile_valid   (tile_valid),
      .tile_done    (tile_done),
      .vga_write_en (vga_write_en),
      .busy         (busy),
      .frame_done   (frame_done),
      .timeout_err  (timeout_err)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // One-cycle registered RAM read.
   always @(posedge clock) begin
      if (ram_rden) ram_rdata <= mem[ram_addr];
   end

   // Event counters and expected row-major address walk.
   always @(negedge clock) begin
      if (clr_mon) begin
         tv_cnt = 0; we_cnt = 0; fd_cnt = 0; rden_cnt = 0; addr_bad = 0; exp_addr = 8'h00;
      end else begin
         if (tile_valid) tv_cnt++;
         if (vga_write_en) we_cnt++;
         if (frame_done) fd_cnt++;
         if (ram_rden) begin
            if (ram_addr !== exp_addr) addr_bad++;
            exp_addr = exp_addr + 8'd1;
            rden_cnt++;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_mon();
      clr_mon = 1'b1;
      @(negedge clock);
      @(posedge clock);
      #1 clr_mon = 1'b0;
   endtask

   task automatic pulse_start();
      @(posedge clock);
      #1 start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
   endtask

   task automatic wait_frame(input string tag, input int limit, output int cycles);
      int found;
      found  = 0;
      cycles = 0;
      while (found == 0 && cycles < limit) begin
         @(negedge clock);
         cycles++;
         if (frame_done) found = 1;
      end
      check({tag, "_frame_done_seen"}, found, 1);
   endtask

   task automatic wait_tv(input string tag, input int limit);
      int found, n;
      found = 0;
      n     = 0;
      while (found == 0 && n < limit) begin
         @(negedge clock);
         n++;
         if (tile_valid) found = 1;
      end
      check({tag, "_tile_valid_seen"}, found, 1);
   endtask

   initial begin
      int cyc;
      int found;
      reset     = 1'b1;
      start     = 1'b0;
      tile_done = 1'b0;
      clr_mon   = 1'b1;
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;

      // Reset state
      @(negedge clock);
      @(negedge clock);
      check("rst_busy", 32'(busy), 0);
      check("rst_tile_valid", 32'(tile_valid), 0);
      check("rst_frame_done", 32'(frame_done), 0);
      check("rst_ram_rden", 32'(ram_rden), 0);
      check("rst_vga_we", 32'(vga_write_en), 0);
      check("rst_timeout_err", 32'(timeout_err), 0);
      check("rst_ram_addr", 32'(ram_addr), 0);
      check("rst_tile_addr", 32'(tile_addr), 0);
      @(posedge clock);
      #1 reset = 1'b0;

      // Empty board: every tile skipped, 3 cycles each
      clear_mon();
      pulse_start();
      check("empty_busy_after_start", 32'(busy), 1);
      wait_frame("empty", 1000, cyc);
      check("empty_frame_cycles", cyc, 769);
      check("empty_busy_at_done", 32'(busy), 0);
      repeat (3) @(negedge clock);
      check("empty_frame_done_count", fd_cnt, 1);
      check("empty_tile_valid_count", tv_cnt, 0);
      check("empty_rden_count", rden_cnt, 256);
      check("empty_addr_errors", addr_bad, 0);
      check("empty_vga_cycles", we_cnt, 0);

      // Single wall at 0x37, drawer done after 256 plotting cycles
      mem[8'h37] = 8'h80;
      clear_mon();
      pulse_start();
      wait_tv("wall", 2000);
      check("wall_tile_addr", 32'(tile_addr), 32'h37);
      check("wall_tile_code", 32'(tile_code), 32'h80);
      repeat (256) @(negedge clock);
      check("wall_vga_mid", 32'(vga_write_en), 1);
      check("wall_addr_stable", 32'(tile_addr), 32'h37);
      @(posedge clock);
      #1 tile_done = 1'b1;
      @(negedge clock);
      check("wall_vga_off_on_done", 32'(vga_write_en), 0);
      @(posedge clock);
      #1 tile_done = 1'b0;
      wait_frame("wall", 2000, cyc);
      repeat (2) @(negedge clock);
      check("wall_vga_cycles", we_cnt, 256);
      check("wall_tile_valid_count", tv_cnt, 1);
      check("wall_timeout_err", 32'(timeout_err), 0);
      check("wall_last_tile_addr", 32'(tile_addr), 32'hFF);
      check("wall_last_tile_code", 32'(tile_code), 32'h00);

      // Stale done held high across two tank tiles
      mem[8'h37] = 8'h00;
      mem[8'h00] = 8'h40;
      mem[8'h01] = 8'h40;
      clear_mon();
      tile_done = 1'b1;
      pulse_start();
      wait_frame("stale", 2000, cyc);
      check("stale_frame_cycles", cyc, 773);
      repeat (2) @(negedge clock);
      check("stale_tile_valid_count", tv_cnt, 2);
      check("stale_vga_cycles", we_cnt, 0);
      tile_done = 1'b0;

      // Drawer never answers: projectile tile at 0x00 times out
      mem[8'h00] = 8'h10;
      mem[8'h01] = 8'h00;
      clear_mon();
      pulse_start();
      wait_frame("tmo", 4000, cyc);
      check("tmo_frame_cycles", cyc, 1793);
      check("tmo_err_set", 32'(timeout_err), 1);
      repeat (2) @(negedge clock);
      check("tmo_vga_cycles", we_cnt, 1023);
      check("tmo_tile_valid_count", tv_cnt, 1);
      check("tmo_rden_count", rden_cnt, 256);
      check("tmo_addr_errors", addr_bad, 0);
      mem[8'h00] = 8'h00;
      pulse_start();
      check("tmo_err_cleared_by_start", 32'(timeout_err), 0);
      wait_frame("tmo2", 1000, cyc);
      check("tmo2_frame_cycles", cyc, 769);
      check("tmo2_err_stays_clear", 32'(timeout_err), 0);

      // Reset while drawing tile 0x52
      mem[8'h52] = 8'h80;
      clear_mon();
      pulse_start();
      wait_tv("rstmid", 2000);
      check("rstmid_tile_addr", 32'(tile_addr), 32'h52);
      @(negedge clock);
      check("rstmid_vga_in_draw", 32'(vga_write_en), 1);
      #2 reset = 1'b1;
      #1;
      check("rstmid_busy", 32'(busy), 0);
      check("rstmid_tile_valid", 32'(tile_valid), 0);
      check("rstmid_vga_we", 32'(vga_write_en), 0);
      check("rstmid_ram_addr", 32'(ram_addr), 0);
      @(posedge clock);
      #1 reset = 1'b0;
      mem[8'h52] = 8'h00;
      clear_mon();
      pulse_start();
      @(negedge clock);
      check("rescan_rden", 32'(ram_rden), 1);
      check("rescan_addr", 32'(ram_addr), 0);
      wait_frame("rescan", 1000, cyc);
      check("rescan_frame_cycles", cyc, 768);
      repeat (2) @(negedge clock);
      check("rescan_rden_count", rden_cnt, 256);
      check("rescan_addr_errors", addr_bad, 0);

      // Start while busy, and start in the frame_done cycle
      clear_mon();
      pulse_start();
      found = 0;
      for (int n = 0; n < 1000 && found == 0; n++) begin
         @(negedge clock);
         if (ram_rden && ram_addr == 8'h10) found = 1;
      end
      check("busy_reached_tile_10", found, 1);
      @(posedge clock);
      #1 start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      check("busy_still_scanning", 32'(busy), 1);
      wait_frame("busy", 1000, cyc);
      start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      check("fdstart_busy_low", 32'(busy), 0);
      repeat (5) @(negedge clock);
      check("fdstart_still_idle", 32'(busy), 0);
      check("busy_frame_done_count", fd_cnt, 1);
      check("busy_rden_count", rden_cnt, 256);
      check("busy_addr_errors", addr_bad, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
